// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU-control decode, 32-bit ALU with HI/LO
// division registers, and EX/MEM store-data forwarding select generation.
module ex_alu_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  Funct,
    input  logic [2:0]  ALUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  Shamt,
    output logic [3:0]  ALUOp,
    output logic [31:0] ALUOut,
    input  logic        MEMWB_MemToReg,
    input  logic        MEMWB_RegWrite,
    input  logic        EXMEM_RegWrite,
    input  logic        EXMEM_MemWrite,
    input  logic [4:0]  IDEX_RegRs,
    input  logic [4:0]  IDEX_RegRt,
    input  logic [4:0]  EXMEM_RegRd,
    input  logic [4:0]  MEMWB_RegRd,
    output logic [1:0]  ForA,
    output logic [1:0]  ForB,
    output logic        ForC
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_LUI  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;
    localparam logic [3:0] OP_MFHI = 4'd9;
    localparam logic [3:0] OP_MFLO = 4'd10;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] mul_lo;
    logic signed [31:0] hi;
    logic signed [31:0] lo;

    assign a_s    = A;
    assign b_s    = B;
    // Only the low word of the product is kept, so a 32-bit signed multiply suffices.
    assign mul_lo = a_s * b_s;

    // Select source for one operand: EX/MEM result wins over MEM/WB; r0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       ex_wr,
                                           input logic [4:0] ex_rd,
                                           input logic       wb_wr,
                                           input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_wr && (ex_rd != 5'd0) && (ex_rd == src))
            sel = 2'b10;
        else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == src))
            sel = 2'b01;
        return sel;
    endfunction

    // Decode instruction class and R-type function field into the ALU operation.
    always_comb begin
        ALUOp = OP_ADD;
        case (ALUCtrl)
            3'd0: ALUOp = OP_ADD;
            3'd1: begin
                case (Funct)
                    6'h20:   ALUOp = OP_ADD;
                    6'h22:   ALUOp = OP_SUB;
                    6'h24:   ALUOp = OP_AND;
                    6'h25:   ALUOp = OP_OR;
                    6'h2A:   ALUOp = OP_SLT;
                    6'h00:   ALUOp = OP_SLL;
                    6'h18:   ALUOp = OP_MUL;
                    6'h1A:   ALUOp = OP_DIV;
                    6'h10:   ALUOp = OP_MFHI;
                    6'h12:   ALUOp = OP_MFLO;
                    default: ALUOp = OP_ADD;   // includes jr (0x08)
                endcase
            end
            3'd2: ALUOp = OP_LUI;
            3'd3: ALUOp = OP_OR;
            3'd4: ALUOp = OP_SUB;
            3'd5: ALUOp = OP_SUB;
            3'd6: ALUOp = OP_ADD;
            3'd7: ALUOp = OP_ADD;
            default: ALUOp = OP_ADD;
        endcase
    end

    // Compute the ALU result; DIV itself and the unused codes produce zero.
    always_comb begin
        ALUOut = 32'd0;
        case (ALUOp)
            OP_ADD:  ALUOut = A + B;
            OP_SUB:  ALUOut = A - B;
            OP_AND:  ALUOut = A & B;
            OP_OR:   ALUOut = A | B;
            OP_SLT:  ALUOut = {31'd0, (a_s < b_s)};
            OP_SLL:  ALUOut = B << Shamt;
            OP_LUI:  ALUOut = {B[15:0], 16'h0000};
            OP_MUL:  ALUOut = mul_lo;
            OP_MFHI: ALUOut = hi;
            OP_MFLO: ALUOut = lo;
            default: ALUOut = 32'd0;
        endcase
    end

    // HI/LO capture signed quotient/remainder on DIV; divide-by-zero leaves them untouched.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hi <= '0;
            lo <= '0;
        end else if ((ALUOp == OP_DIV) && (B != 32'd0)) begin
            lo <= a_s / b_s;
            hi <= a_s % b_s;
        end
    end

    // Forwarding selects for the EX operand muxes and the MEM store-data mux.
    always_comb begin
        ForA = fwd_sel(IDEX_RegRs, EXMEM_RegWrite, EXMEM_RegRd, MEMWB_RegWrite, MEMWB_RegRd);
        ForB = fwd_sel(IDEX_RegRt, EXMEM_RegWrite, EXMEM_RegRd, MEMWB_RegWrite, MEMWB_RegRd);
        ForC = EXMEM_MemWrite && MEMWB_RegWrite && MEMWB_MemToReg &&
               (MEMWB_RegRd != 5'd0) && (MEMWB_RegRd == EXMEM_RegRd);
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed vectors with a scoreboard queue; a negedge monitor
// pops each expectation and compares it against the combinational outputs.
module tb_ex_alu_unit;

    logic        Clock;
    logic        Reset;
    logic [5:0]  Funct;
    logic [2:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic [3:0]  ALUOp;
    logic [31:0] ALUOut;
    logic        MEMWB_MemToReg;
    logic        MEMWB_RegWrite;
    logic        EXMEM_RegWrite;
    logic        EXMEM_MemWrite;
    logic [4:0]  IDEX_RegRs;
    logic [4:0]  IDEX_RegRt;
    logic [4:0]  EXMEM_RegRd;
    logic [4:0]  MEMWB_RegRd;
    logic [1:0]  ForA;
    logic [1:0]  ForB;
    logic        ForC;

    ex_alu_unit dut (
        .Clock(Clock), .Reset(Reset), .Funct(Funct), .ALUCtrl(ALUCtrl),
        .A(A), .B(B), .Shamt(Shamt), .ALUOp(ALUOp), .ALUOut(ALUOut),
        .MEMWB_MemToReg(MEMWB_MemToReg), .MEMWB_RegWrite(MEMWB_RegWrite),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemWrite(EXMEM_MemWrite),
        .IDEX_RegRs(IDEX_RegRs), .IDEX_RegRt(IDEX_RegRt),
        .EXMEM_RegRd(EXMEM_RegRd), .MEMWB_RegRd(MEMWB_RegRd),
        .ForA(ForA), .ForB(ForB), .ForC(ForC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        bit          chk_alu;
        logic [3:0]  op;
        logic [31:0] out;
        bit          chk_fwd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        fc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_vld = 1'b0;
    logic rst_drv = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: one expectation is consumed per presented vector.
    always @(negedge Clock) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got 0 entries expected 1");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_alu) begin
                    check({e.name, ".op"}, {28'd0, ALUOp}, {28'd0, e.op});
                    check({e.name, ".out"}, ALUOut, e.out);
                end
                if (e.chk_fwd) begin
                    check({e.name, ".ForA"}, {30'd0, ForA}, {30'd0, e.fa});
                    check({e.name, ".ForB"}, {30'd0, ForB}, {30'd0, e.fb});
                    check({e.name, ".ForC"}, {31'd0, ForC}, {31'd0, e.fc});
                end
            end
        end
    end

    task automatic alu(input string nm, input logic [2:0] ctrl, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [3:0] eop, input logic [31:0] eout);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = rst_drv; ALUCtrl = ctrl; Funct = fn; A = a; B = b; Shamt = sh;
        e.name = nm; e.chk_alu = 1'b1; e.op = eop; e.out = eout;
        e.chk_fwd = 1'b0; e.fa = 2'b00; e.fb = 2'b00; e.fc = 1'b0;
        sb.push_back(e);
        chk_vld = 1'b1;
    endtask

    task automatic fwd(input string nm, input logic exw, input logic wbw, input logic exm,
                       input logic m2r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] exrd, input logic [4:0] wbrd,
                       input logic [1:0] efa, input logic [1:0] efb, input logic efc);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = rst_drv;
        EXMEM_RegWrite = exw; MEMWB_RegWrite = wbw; EXMEM_MemWrite = exm;
        MEMWB_MemToReg = m2r; IDEX_RegRs = rs; IDEX_RegRt = rt;
        EXMEM_RegRd = exrd; MEMWB_RegRd = wbrd;
        e.name = nm; e.chk_alu = 1'b0; e.op = 4'd0; e.out = 32'd0;
        e.chk_fwd = 1'b1; e.fa = efa; e.fb = efb; e.fc = efc;
        sb.push_back(e);
        chk_vld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; Funct = 6'd0; ALUCtrl = 3'd0; A = 32'd0; B = 32'd0; Shamt = 5'd0;
        MEMWB_MemToReg = 1'b0; MEMWB_RegWrite = 1'b0; EXMEM_RegWrite = 1'b0;
        EXMEM_MemWrite = 1'b0; IDEX_RegRs = 5'd0; IDEX_RegRt = 5'd0;
        EXMEM_RegRd = 5'd0; MEMWB_RegRd = 5'd0;
        repeat (3) @(posedge Clock);

        // Reset state of HI/LO
        alu("rst_mfhi", 3'd1, 6'h10, 32'd5, 32'd7, 5'd0, 4'd9,  32'd0);
        alu("rst_mflo", 3'd1, 6'h12, 32'd5, 32'd7, 5'd0, 4'd10, 32'd0);

        // R-type functions
        alu("r_add",   3'd1, 6'h20, 32'h12345678, 32'h11111111, 5'd0,  4'd0, 32'h23456789);
        alu("r_sub",   3'd1, 6'h22, 32'd5,        32'd7,        5'd0,  4'd1, 32'hFFFFFFFE);
        alu("r_and",   3'd1, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  4'd2, 32'hF000F000);
        alu("r_or",    3'd1, 6'h25, 32'h0F0F0000, 32'h000000FF, 5'd0,  4'd3, 32'h0F0F00FF);
        alu("r_slt1",  3'd1, 6'h2A, 32'hFFFFFFFF, 32'd1,        5'd0,  4'd4, 32'd1);
        alu("r_slt0",  3'd1, 6'h2A, 32'd1,        32'hFFFFFFFF, 5'd0,  4'd4, 32'd0);
        alu("r_sll4",  3'd1, 6'h00, 32'd0,        32'd3,        5'd4,  4'd5, 32'h00000030);
        alu("r_sll31", 3'd1, 6'h00, 32'd0,        32'd1,        5'd31, 4'd5, 32'h80000000);
        alu("mul_m1",  3'd1, 6'h18, 32'hFFFFFFFF, 32'd1,        5'd0,  4'd7, 32'hFFFFFFFF);
        alu("mul_z",   3'd1, 6'h18, 32'hFFFFFFFF, 32'd0,        5'd0,  4'd7, 32'd0);
        alu("mul_neg", 3'd1, 6'h18, 32'hFFFFFFFE, 32'd3,        5'd0,  4'd7, 32'hFFFFFFFA);
        alu("mul_wrap",3'd1, 6'h18, 32'h00010000, 32'h00010000, 5'd0,  4'd7, 32'd0);
        alu("r_jr",    3'd1, 6'h08, 32'd100,      32'd23,       5'd0,  4'd0, 32'd123);
        alu("r_unk",   3'd1, 6'h3F, 32'd1,        32'd2,        5'd0,  4'd0, 32'd3);

        // ALUCtrl sweep with B = 0x1234ABCD, A = 0x0000F000
        alu("c_add", 3'd0, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd0, 32'h12359BCD);
        alu("c_lui", 3'd2, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd6, 32'hABCD0000);
        alu("c_ori", 3'd3, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd3, 32'h1234FBCD);
        alu("c_beq", 3'd4, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd1, 32'hEDCC4433);
        alu("c_bne", 3'd5, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd1, 32'hEDCC4433);
        alu("c_j",   3'd6, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd0, 32'h12359BCD);
        alu("c_jal", 3'd7, 6'h00, 32'h0000F000, 32'h1234ABCD, 5'd0, 4'd0, 32'h12359BCD);

        // Division through HI/LO
        alu("div_6_3",   3'd1, 6'h1A, 32'd6,  32'd3, 5'd0, 4'd8,  32'd0);
        alu("hi_6_3",    3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'd0);
        alu("lo_6_3",    3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'd2);
        alu("div_1_3",   3'd1, 6'h1A, 32'd1,  32'd3, 5'd0, 4'd8,  32'd0);
        alu("hi_1_3",    3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'd1);
        alu("lo_1_3",    3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'd0);
        alu("div_11_3",  3'd1, 6'h1A, 32'd11, 32'd3, 5'd0, 4'd8,  32'd0);
        alu("hi_11_3",   3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'd2);
        alu("lo_11_3",   3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'd3);
        alu("div_m7_2",  3'd1, 6'h1A, 32'hFFFFFFF9, 32'd2, 5'd0, 4'd8, 32'd0);
        alu("hi_m7_2",   3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'hFFFFFFFF);
        alu("lo_m7_2",   3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'hFFFFFFFD);
        alu("div_by0",   3'd1, 6'h1A, 32'd5,  32'd0, 5'd0, 4'd8,  32'd0);
        alu("hi_by0",    3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'hFFFFFFFF);
        alu("lo_by0",    3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'hFFFFFFFD);
        alu("b2b_div1",  3'd1, 6'h1A, 32'd20, 32'd6, 5'd0, 4'd8,  32'd0);
        alu("b2b_div2",  3'd1, 6'h1A, 32'd11, 32'd3, 5'd0, 4'd8,  32'd0);
        alu("hi_b2b",    3'd1, 6'h10, 32'd0,  32'd0, 5'd0, 4'd9,  32'd2);
        alu("lo_b2b",    3'd1, 6'h12, 32'd0,  32'd0, 5'd0, 4'd10, 32'd3);
        rst_drv = 1'b0;
        alu("div_in_rst", 3'd1, 6'h1A, 32'd10, 32'd3, 5'd0, 4'd8, 32'd0);
        rst_drv = 1'b1;
        alu("hi_after_rst", 3'd1, 6'h10, 32'd0, 32'd0, 5'd0, 4'd9,  32'd0);
        alu("lo_after_rst", 3'd1, 6'h12, 32'd0, 32'd0, 5'd0, 4'd10, 32'd0);

        // Operand forwarding, rs = 5, rt = 7
        fwd("fa_both",   1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd5, 5'd5, 2'b10, 2'b00, 1'b0);
        fwd("fa_wbonly", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd5, 5'd5, 2'b01, 2'b00, 1'b0);
        fwd("fb_wb",     1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd5, 5'd7, 2'b10, 2'b01, 1'b0);
        fwd("fb_ex",     1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd7, 5'd7, 2'b00, 2'b10, 1'b0);
        fwd("r0_nofwd",  1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        fwd("fab_same",  1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 5'd3, 2'b10, 2'b10, 1'b0);

        // Store-data forwarding
        fwd("fc_on",     1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd7, 5'd9, 5'd9, 2'b00, 2'b00, 1'b1);
        fwd("fc_nomw",   1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd7, 5'd9, 5'd9, 2'b00, 2'b00, 1'b0);
        fwd("fc_nom2r",  1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd7, 5'd9, 5'd9, 2'b00, 2'b00, 1'b0);
        fwd("fc_nowbw",  1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd7, 5'd9, 5'd9, 2'b00, 2'b00, 1'b0);
        fwd("fc_rdne",   1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd7, 5'd9, 5'd8, 2'b00, 2'b00, 1'b0);
        fwd("fc_r0",     1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd7, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);

        @(posedge Clock);
        #1;
        chk_vld = 1'b0;
        repeat (2) @(posedge Clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
